// File: rtl/jpeg_idct_pkg.sv
// Shared definitions for the IDCT transpose stage: block geometry, sequencer
// states and the row-major to column-pair-major address mapping.
package jpeg_idct_pkg;

  localparam int BLK_WORDS = 32;
  localparam int IDX_W     = 5;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Read index walks rows fastest: row = idx[2:0], word-in-row = idx[4:3].
  function automatic logic [IDX_W-1:0] transpose_addr(input logic [IDX_W-1:0] idx);
    return {idx[2:0], idx[4:3]};
  endfunction

endpackage

// File: rtl/jpeg_idct_transpose_fifo2.sv
// Two-entry output buffer for transposed words ({last, data}); exposes its
// occupancy so the sequencer can throttle RAM reads.
module jpeg_idct_transpose_fifo2 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [32:0] push_data_i,
  input  logic        pop_i,
  output logic        valid_o,
  output logic [32:0] data_o,
  output logic [1:0]  count_o
);

  logic [32:0] mem_q [2];
  logic [32:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_push;
  logic        do_pop;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = !wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = !rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // NOTE: flops take non-blocking assignments so every one samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: storage is reset here (unlike a RAM) so the head data reads 0 straight out of reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/jpeg_idct_transpose_ctrl.sv
// Transpose-RAM sequencer between IDCT row and column passes: fills one 8x8
// block row-major through port 0, drains it column-pair-major through port 1.
module jpeg_idct_transpose_ctrl
  import jpeg_idct_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  output logic        outport_last_o,
  input  logic        outport_accept_i,
  output logic        busy_o,
  output logic [4:0]  ram_addr0_o,
  output logic [31:0] ram_data0_o,
  output logic        ram_wr0_o,
  output logic [4:0]  ram_addr1_o,
  output logic [31:0] ram_data1_o,
  output logic        ram_wr1_o,
  input  logic [31:0] ram_data1_i
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;

  logic        wr_en;
  logic        rd_issue;
  logic        fifo_pop;
  logic        fifo_valid;
  logic [1:0]  fifo_count;
  logic [2:0]  occupancy;
  logic [32:0] fifo_head;

  always_comb begin
    wr_en     = (state_q == ST_FILL) && inport_valid_i && !flush_i;
    fifo_pop  = fifo_valid && outport_accept_i;
    // The word leaving this cycle frees its slot now, which keeps a streaming drain at one read per cycle.
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    rd_issue  = (state_q == ST_DRAIN) && !flush_i && (occupancy < 3'd2);
  end

  always_comb begin
    state_d         = state_q;
    wr_idx_d        = wr_idx_q;
    rd_idx_d        = rd_idx_q;
    inflight_d      = rd_issue;
    inflight_last_d = rd_issue && (rd_idx_q == IDX_LAST);
    if (flush_i) begin
      state_d  = ST_FILL;
      wr_idx_d = '0;
      rd_idx_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: begin
          if (wr_en) begin
            wr_idx_d = wr_idx_q + 5'd1;
            if (wr_idx_q == IDX_LAST) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (rd_issue) begin
            rd_idx_d = rd_idx_q + 5'd1;
            if (rd_idx_q == IDX_LAST) state_d = ST_FILL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= ST_IDLE;
      wr_idx_q        <= '0;
      rd_idx_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  jpeg_idct_transpose_fifo2 u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, ram_data1_i}),
    .pop_i       (fifo_pop),
    .valid_o     (fifo_valid),
    .data_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign inport_accept_o = (state_q == ST_FILL);
  assign ram_wr0_o       = wr_en;
  assign ram_addr0_o     = wr_idx_q;
  assign ram_data0_o     = wr_en ? inport_data_i : 32'd0;
  assign ram_addr1_o     = transpose_addr(rd_idx_q);
  assign ram_data1_o     = 32'd0;
  assign ram_wr1_o       = 1'b0;
  assign outport_valid_o = fifo_valid;
  assign outport_last_o  = fifo_head[32];
  assign outport_data_o  = fifo_head[31:0];
  // Gated by reset so that every output reads 0 while reset is held, IDLE included.
  assign busy_o = rst_i && ((state_q != ST_FILL) || (wr_idx_q != '0) || (fifo_count != 2'd0));

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// Self-checking bench for jpeg_idct_transpose_ctrl: random and patterned blocks
// scored against a block-level transpose model, with a behavioural RAM beside it.
module tb_jpeg_idct_transpose_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        inport_valid_i;
  logic [31:0] inport_data_i;
  logic        inport_accept_o;
  logic        outport_valid_o;
  logic [31:0] outport_data_o;
  logic        outport_last_o;
  logic        outport_accept_i;
  logic        busy_o;
  logic [4:0]  ram_addr0_o;
  logic [31:0] ram_data0_o;
  logic        ram_wr0_o;
  logic [4:0]  ram_addr1_o;
  logic [31:0] ram_data1_o;
  logic        ram_wr1_o;
  logic [31:0] ram_data1_i;

  always #5 clk_i = ~clk_i;

  jpeg_idct_transpose_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_accept_o  (inport_accept_o),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_last_o   (outport_last_o),
    .outport_accept_i (outport_accept_i),
    .busy_o           (busy_o),
    .ram_addr0_o      (ram_addr0_o),
    .ram_data0_o      (ram_data0_o),
    .ram_wr0_o        (ram_wr0_o),
    .ram_addr1_o      (ram_addr1_o),
    .ram_data1_o      (ram_data1_o),
    .ram_wr1_o        (ram_wr1_o),
    .ram_data1_i      (ram_data1_i)
  );

  // Read-first dual-port RAM with one cycle of read latency.
  logic [31:0] ram_mem [32];
  always @(posedge clk_i) begin
    if (ram_wr0_o) ram_mem[ram_addr0_o] <= ram_data0_o;
    ram_data1_i <= ram_mem[ram_addr1_o];
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [32:0] exp_q[$];
  logic [31:0] blk_words [32];
  int          model_wr_cnt = 0;
  int          blk_start_cyc = 0;
  int          prev_blk_start_cyc = 0;
  int          out_in_blk = 0;
  int          out_first_cyc = 0;
  int          out_span = -1;
  bit          in_fire;
  int          oacc_mode = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_accept"}, inport_accept_o, 0);
    check({tag, "_out_valid"}, outport_valid_o, 0);
    check({tag, "_out_data"},  outport_data_o, 0);
    check({tag, "_out_last"},  outport_last_o, 0);
    check({tag, "_busy"},      busy_o, 0);
    check({tag, "_addr0"},     ram_addr0_o, 0);
    check({tag, "_data0"},     ram_data0_o, 0);
    check({tag, "_wr0"},       ram_wr0_o, 0);
    check({tag, "_addr1"},     ram_addr1_o, 0);
    check({tag, "_data1"},     ram_data1_o, 0);
    check({tag, "_wr1"},       ram_wr1_o, 0);
  endtask

  // Block-level model: 32 accepted words become expected outputs in transposed order.
  task automatic observe();
    logic [32:0] exp_word;
    check("ram_wr0", ram_wr0_o, inport_valid_i && inport_accept_o && !flush_i);
    if (outport_valid_o && outport_accept_i && !flush_i) begin
      check("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check("out_word", {outport_last_o, outport_data_o}, exp_word);
        if (out_in_blk == 0) out_first_cyc = cyc;
        out_in_blk++;
        if (exp_word[32]) begin
          out_span   = cyc - out_first_cyc;
          out_in_blk = 0;
        end
      end
    end
    in_fire = inport_valid_i && inport_accept_o;
    if (flush_i) begin
      model_wr_cnt = 0;
      out_in_blk   = 0;
      exp_q.delete();
    end else if (in_fire) begin
      check("wr_addr", ram_addr0_o, model_wr_cnt);
      check("wr_data", ram_data0_o, inport_data_i);
      if (model_wr_cnt == 0) begin
        prev_blk_start_cyc = blk_start_cyc;
        blk_start_cyc      = cyc;
      end
      blk_words[model_wr_cnt] = inport_data_i;
      model_wr_cnt++;
      if (model_wr_cnt == 32) begin
        for (int j = 0; j < 32; j++)
          exp_q.push_back({(j == 31), blk_words[(j % 8) * 4 + j / 8]});
        model_wr_cnt = 0;
      end
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle();
    case (oacc_mode)
      0:       outport_accept_i = 1'b1;
      1:       outport_accept_i = ((cyc % 40) >= 20 && (cyc % 40) < 30) ? 1'b0 : cyc[0];
      default: outport_accept_i = 1'b0;
    endcase
    #1;
    observe();
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic send_words(input logic [31:0] base, input bit rand_data,
                            input int gap_pct, input int n_words);
    int          k = 0;
    int          guard = 0;
    logic [31:0] word;
    word = rand_data ? $urandom : base;
    while (k < n_words && guard < 400) begin
      inport_valid_i = ($urandom_range(99) >= gap_pct);
      inport_data_i  = word;
      cycle();
      if (in_fire) begin
        k++;
        word = rand_data ? $urandom : base + k;
      end
      guard++;
    end
    inport_valid_i = 1'b0;
    check("send_done", k, n_words);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || outport_valid_o) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i            = 1'b0;
    flush_i          = 1'b0;
    inport_valid_i   = 1'b1;
    inport_data_i    = 32'hFFFF_FFFF;
    outport_accept_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");

    inport_valid_i = 1'b0;
    rst_i          = 1'b1;
    #1;
    check("idle_accept", inport_accept_o, 0);
    check("idle_busy", busy_o, 1);
    @(negedge clk_i);
    #1;
    check("fill_accept", inport_accept_o, 1);
    check("fill_busy", busy_o, 0);
    @(negedge clk_i);

    // Incrementing block, no backpressure.
    oacc_mode = 0;
    send_words(32'd0, 1'b0, 0, 32);
    wait_drain(200);
    check("t1_out_span", out_span, 31);
    check("t1_busy_after", busy_o, 0);

    // Random blocks with gappy input and toggling/stalled output.
    oacc_mode = 1;
    send_words(32'd0, 1'b1, 30, 32);
    send_words(32'd0, 1'b1, 0, 32);
    wait_drain(400);

    // Back-to-back blocks streaming.
    oacc_mode = 0;
    send_words(32'd0, 1'b0, 0, 32);
    send_words(32'h100, 1'b0, 0, 32);
    check("b2b_gap", blk_start_cyc - prev_blk_start_cyc, 64);
    wait_drain(200);
    check("b2b_out_span", out_span, 31);

    // Flush mid-fill, then a fresh block.
    send_words(32'h1234_0000, 1'b0, 0, 17);
    flush_i        = 1'b1;
    inport_valid_i = 1'b1;
    inport_data_i  = 32'hDEAD_BEEF;
    cycle();
    flush_i        = 1'b0;
    inport_valid_i = 1'b0;
    #1;
    check("flush_busy", busy_o, 0);
    @(negedge clk_i);
    send_words(32'hA5A5_0000, 1'b0, 0, 32);
    wait_drain(200);
    repeat (5) cycle();

    // Flush while draining with the output buffer full.
    oacc_mode = 2;
    send_words(32'd0, 1'b1, 0, 32);
    repeat (6) cycle();
    check("pre_flush_valid", outport_valid_o, 1);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check("post_flush_valid", outport_valid_o, 0);
    oacc_mode = 0;
    send_words(32'd0, 1'b1, 10, 32);
    wait_drain(200);

    // Asynchronous reset during drain with the buffer full.
    oacc_mode = 2;
    send_words(32'd0, 1'b1, 0, 32);
    repeat (6) cycle();
    check("pre_rst_valid", outport_valid_o, 1);
    inport_valid_i = 1'b1;
    inport_data_i  = 32'h5A5A_5A5A;
    #2;
    rst_i = 1'b0;
    #1;
    check_all_zero("rst_mid");
    exp_q.delete();
    model_wr_cnt = 0;
    out_in_blk   = 0;
    @(negedge clk_i);
    rst_i          = 1'b1;
    inport_valid_i = 1'b0;
    oacc_mode      = 0;
    send_words(32'd0, 1'b1, 0, 32);
    wait_drain(200);
    check("final_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
